// File: rtl/pe_spad_loader.sv
// Fills the PE filter scratchpad once per pass and the ifmap scratchpad once per
// input channel from show-ahead FIFOs, holding the PE controller in await until data is resident.
module pe_spad_loader #(
   parameter int S_WIDTH           = 4,
   parameter int q_WIDTH           = 3,
   parameter int p_WIDTH           = 5,
   parameter int n_WIDTH           = 3,
   parameter int IFMAP_ADDR_WIDTH  = 4,
   parameter int FILTER_ADDR_WIDTH = 8,
   parameter int DATA_WIDTH        = 16
) (
   input  logic                         clk,
   input  logic                         reset_n,
   input  logic                         load_start,
   output logic                         load_busy,
   input  logic [S_WIDTH-1:0]           S,
   input  logic [q_WIDTH-1:0]           q,
   input  logic [p_WIDTH-1:0]           p,
   input  logic [n_WIDTH-1:0]           n,
   input  logic                         filter_fifo_empty,
   output logic                         filter_fifo_rd_en,
   input  logic [DATA_WIDTH-1:0]        filter_fifo_dout,
   input  logic                         ifmap_fifo_empty,
   output logic                         ifmap_fifo_rd_en,
   input  logic [DATA_WIDTH-1:0]        ifmap_fifo_dout,
   output logic                         filter_wr_en,
   output logic [FILTER_ADDR_WIDTH-1:0] filter_wr_addr,
   output logic [DATA_WIDTH-1:0]        filter_wr_data,
   output logic                         ifmap_wr_en,
   output logic [IFMAP_ADDR_WIDTH-1:0]  ifmap_wr_addr,
   output logic [DATA_WIDTH-1:0]        ifmap_wr_data,
   output logic                         pe_start,
   output logic                         pe_await,
   input  logic                         pe_reset_ifmap_spad,
   input  logic                         pe_busy
);

   // Totals are sized as the sum of their factor widths so the products never truncate.
   localparam int FT_W = S_WIDTH + q_WIDTH + p_WIDTH;
   localparam int IT_W = S_WIDTH + q_WIDTH;

   typedef enum logic [2:0] {
      IDLE,
      LOAD_FILTER,
      LOAD_IFMAP,
      RUN,
      DRAIN
   } state_t;

   state_t              state_reg, state_next;
   logic [S_WIDTH-1:0]  s_reg, s_next;
   logic [q_WIDTH-1:0]  q_reg, q_next;
   logic [p_WIDTH-1:0]  p_reg, p_next;
   logic [n_WIDTH-1:0]  n_reg, n_next;
   logic [FT_W-1:0]     k_reg, k_next;
   logic [IT_W-1:0]     m_reg, m_next;
   logic [n_WIDTH-1:0]  ch_reg, ch_next;
   logic                start_reg, start_next;

   logic [FT_W-1:0]     ft_total;
   logic [IT_W-1:0]     it_total;
   logic                shape_ok;

   assign ft_total = FT_W'(s_reg) * FT_W'(q_reg) * FT_W'(p_reg);
   assign it_total = IT_W'(s_reg) * IT_W'(q_reg);
   assign shape_ok = (|S) && (|q) && (|p) && (|n);

   assign load_busy      = (state_reg != IDLE);
   assign pe_await       = (state_reg != RUN);
   assign pe_start       = start_reg;
   assign filter_wr_addr = FILTER_ADDR_WIDTH'(k_reg);
   assign ifmap_wr_addr  = IFMAP_ADDR_WIDTH'(m_reg);
   assign filter_wr_data = filter_fifo_dout;
   assign ifmap_wr_data  = ifmap_fifo_dout;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_reg <= IDLE;
         s_reg     <= '0;
         q_reg     <= '0;
         p_reg     <= '0;
         n_reg     <= '0;
         k_reg     <= '0;
         m_reg     <= '0;
         ch_reg    <= '0;
         start_reg <= 1'b0;
      end else begin
         state_reg <= state_next;
         s_reg     <= s_next;
         q_reg     <= q_next;
         p_reg     <= p_next;
         n_reg     <= n_next;
         k_reg     <= k_next;
         m_reg     <= m_next;
         ch_reg    <= ch_next;
         start_reg <= start_next;
      end
   end

   always_comb begin
      state_next        = state_reg;
      s_next            = s_reg;
      q_next            = q_reg;
      p_next            = p_reg;
      n_next            = n_reg;
      k_next            = k_reg;
      m_next            = m_reg;
      ch_next           = ch_reg;
      start_next        = 1'b0;
      filter_fifo_rd_en = 1'b0;
      filter_wr_en      = 1'b0;
      ifmap_fifo_rd_en  = 1'b0;
      ifmap_wr_en       = 1'b0;

      case (state_reg)
         IDLE: begin
            if (load_start && shape_ok) begin
               s_next     = S;
               q_next     = q;
               p_next     = p;
               n_next     = n;
               start_next = 1'b1;
               state_next = LOAD_FILTER;
            end
         end
         LOAD_FILTER: begin
            if (!filter_fifo_empty) begin
               filter_fifo_rd_en = 1'b1;
               filter_wr_en      = 1'b1;
               if (k_reg == ft_total - FT_W'(1)) begin
                  k_next     = '0;
                  state_next = LOAD_IFMAP;
               end else begin
                  k_next = k_reg + FT_W'(1);
               end
            end
         end
         LOAD_IFMAP: begin
            if (!ifmap_fifo_empty) begin
               ifmap_fifo_rd_en = 1'b1;
               ifmap_wr_en      = 1'b1;
               if (m_reg == it_total - IT_W'(1)) begin
                  m_next     = '0;
                  state_next = RUN;
               end else begin
                  m_next = m_reg + IT_W'(1);
               end
            end
         end
         RUN: begin
            // The controller's ifmap-spad reset marks the current channel as consumed.
            if (pe_reset_ifmap_spad) begin
               if (ch_reg == n_reg - n_WIDTH'(1)) begin
                  ch_next    = '0;
                  state_next = DRAIN;
               end else begin
                  ch_next    = ch_reg + n_WIDTH'(1);
                  state_next = LOAD_IFMAP;
               end
            end
         end
         DRAIN: begin
            if (!pe_busy) begin
               state_next = IDLE;
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_pe_spad_loader.sv
// Directed bench for pe_spad_loader: FIFO-fed filter/ifmap loads, multi-channel
// reloads, FIFO stalls, mid-load reset and ignored control events.
module tb_pe_spad_loader;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        load_start;
   logic        load_busy;
   logic [3:0]  S;
   logic [2:0]  q;
   logic [4:0]  p;
   logic [2:0]  n;
   logic        filter_fifo_empty;
   logic        filter_fifo_rd_en;
   logic [15:0] filter_fifo_dout;
   logic        ifmap_fifo_empty;
   logic        ifmap_fifo_rd_en;
   logic [15:0] ifmap_fifo_dout;
   logic        filter_wr_en;
   logic [7:0]  filter_wr_addr;
   logic [15:0] filter_wr_data;
   logic        ifmap_wr_en;
   logic [3:0]  ifmap_wr_addr;
   logic [15:0] ifmap_wr_data;
   logic        pe_start;
   logic        pe_await;
   logic        pe_reset_ifmap_spad;
   logic        pe_busy;

   int total = 0;
   int fails = 0;
   int filt_pops = 0;
   int ifm_pops = 0;
   int fwr_cnt = 0;
   int exp_f = 0;
   int exp_i = 0;
   int fbase;

   always #5 clk = ~clk;

   pe_spad_loader dut (
      .clk                 (clk),
      .reset_n             (reset_n),
      .load_start          (load_start),
      .load_busy           (load_busy),
      .S                   (S),
      .q                   (q),
      .p                   (p),
      .n                   (n),
      .filter_fifo_empty   (filter_fifo_empty),
      .filter_fifo_rd_en   (filter_fifo_rd_en),
      .filter_fifo_dout    (filter_fifo_dout),
      .ifmap_fifo_empty    (ifmap_fifo_empty),
      .ifmap_fifo_rd_en    (ifmap_fifo_rd_en),
      .ifmap_fifo_dout     (ifmap_fifo_dout),
      .filter_wr_en        (filter_wr_en),
      .filter_wr_addr      (filter_wr_addr),
      .filter_wr_data      (filter_wr_data),
      .ifmap_wr_en         (ifmap_wr_en),
      .ifmap_wr_addr       (ifmap_wr_addr),
      .ifmap_wr_data       (ifmap_wr_data),
      .pe_start            (pe_start),
      .pe_await            (pe_await),
      .pe_reset_ifmap_spad (pe_reset_ifmap_spad),
      .pe_busy             (pe_busy)
   );

   // Show-ahead FIFO models: head word is a base plus the number of pops so far.
   assign filter_fifo_dout = 16'h1000 + 16'(filt_pops);
   assign ifmap_fifo_dout  = 16'h2000 + 16'(ifm_pops);

   always @(posedge clk) begin
      if (filter_fifo_rd_en) filt_pops <= filt_pops + 1;
      if (ifmap_fifo_rd_en)  ifm_pops  <= ifm_pops + 1;
      if (filter_wr_en)      fwr_cnt   <= fwr_cnt + 1;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic filter_writes(input int cnt, input int a0);
      for (int i = 0; i < cnt; i++) begin
         chk("filter_wr_en", filter_wr_en, 1);
         chk("filter_rd_en", filter_fifo_rd_en, 1);
         chk("filter_wr_addr", filter_wr_addr, a0 + i);
         chk("filter_wr_data", filter_wr_data, 32'h1000 + exp_f);
         chk("ifmap_rd_en_in_filter", ifmap_fifo_rd_en, 0);
         chk("await_in_filter", pe_await, 1);
         $display("filter write addr=%0d data=%h", filter_wr_addr, filter_wr_data);
         exp_f++;
         tick();
      end
   endtask

   task automatic ifmap_writes(input int cnt);
      for (int i = 0; i < cnt; i++) begin
         chk("ifmap_wr_en", ifmap_wr_en, 1);
         chk("ifmap_wr_addr", ifmap_wr_addr, i);
         chk("ifmap_wr_data", ifmap_wr_data, 32'h2000 + exp_i);
         chk("filter_rd_en_in_ifmap", filter_fifo_rd_en, 0);
         chk("await_in_ifmap", pe_await, 1);
         $display("ifmap write addr=%0d data=%h", ifmap_wr_addr, ifmap_wr_data);
         exp_i++;
         tick();
      end
   endtask

   task automatic start_pass();
      load_start = 1'b1;
      tick();
      load_start = 1'b0;
      #1;
   endtask

   task automatic pulse_reset_spad();
      pe_reset_ifmap_spad = 1'b1;
      tick();
      pe_reset_ifmap_spad = 1'b0;
      #1;
   endtask

   initial begin
      reset_n             = 1'b0;
      load_start          = 1'b0;
      S                   = 4'd3;
      q                   = 3'd2;
      p                   = 5'd4;
      n                   = 3'd1;
      filter_fifo_empty   = 1'b0;
      ifmap_fifo_empty    = 1'b0;
      pe_reset_ifmap_spad = 1'b0;
      pe_busy             = 1'b0;
      #12;
      chk("rst_load_busy", load_busy, 0);
      chk("rst_pe_start", pe_start, 0);
      chk("rst_pe_await", pe_await, 1);
      chk("rst_filter_rd_en", filter_fifo_rd_en, 0);
      chk("rst_ifmap_rd_en", ifmap_fifo_rd_en, 0);
      chk("rst_filter_wr_en", filter_wr_en, 0);
      chk("rst_ifmap_wr_en", ifmap_wr_en, 0);
      chk("rst_filter_addr", filter_wr_addr, 0);
      chk("rst_ifmap_addr", ifmap_wr_addr, 0);
      reset_n = 1'b1;
      tick();

      // load_start with p=0 is ignored
      p = 5'd0;
      start_pass();
      chk("p0_pe_start", pe_start, 0);
      chk("p0_load_busy", load_busy, 0);
      chk("p0_filter_wr_en", filter_wr_en, 0);
      tick();
      chk("p0_load_busy_later", load_busy, 0);
      $display("txn: ignored load_start with p=0");

      // Pass 1: S=3 q=2 p=4 n=1
      p = 5'd4;
      start_pass();
      chk("t1_pe_start", pe_start, 1);
      chk("t1_load_busy", load_busy, 1);
      fbase = fwr_cnt;
      filter_writes(1, 0);
      chk("t1_pe_start_drop", pe_start, 0);
      filter_writes(23, 1);
      ifmap_writes(6);
      chk("t1_await_low", pe_await, 0);
      chk("t1_ifmap_wr_idle", ifmap_wr_en, 0);
      chk("t1_busy_run", load_busy, 1);
      pe_busy = 1'b1;
      pulse_reset_spad();
      chk("t1_drain_await", pe_await, 1);
      chk("t1_drain_busy", load_busy, 1);
      tick();
      chk("t1_drain_hold", load_busy, 1);
      pe_busy = 1'b0;
      tick();
      chk("t1_idle_busy", load_busy, 0);
      chk("t1_filter_total", fwr_cnt - fbase, 24);
      $display("txn: pass n=1 complete");

      // Pass 2: n=3, three ifmap loads, load_start during RUN ignored
      n = 3'd3;
      start_pass();
      fbase = fwr_cnt;
      filter_writes(24, 0);
      ifmap_writes(6);
      chk("t2_await_low0", pe_await, 0);
      tick();
      chk("t2_await_low0b", pe_await, 0);
      load_start = 1'b1;
      tick();
      load_start = 1'b0;
      #1;
      chk("t2_run_start_ignored", pe_start, 0);
      chk("t2_run_still", pe_await, 0);
      chk("t2_run_no_filter", filter_wr_en, 0);
      pulse_reset_spad();
      ifmap_writes(6);
      chk("t2_await_low1", pe_await, 0);
      pulse_reset_spad();
      ifmap_writes(6);
      chk("t2_await_low2", pe_await, 0);
      pulse_reset_spad();
      chk("t2_drain_busy", load_busy, 1);
      chk("t2_drain_no_ifmap", ifmap_wr_en, 0);
      tick();
      chk("t2_idle_busy", load_busy, 0);
      chk("t2_filter_total", fwr_cnt - fbase, 24);
      $display("txn: pass n=3 complete");

      // Pass 3: filter FIFO empty for 5 cycles at k=10, spad reset ignored meanwhile
      n = 3'd1;
      start_pass();
      filter_writes(10, 0);
      filter_fifo_empty   = 1'b1;
      pe_reset_ifmap_spad = 1'b1;
      #1;
      for (int i = 0; i < 5; i++) begin
         chk("stall_wr_en", filter_wr_en, 0);
         chk("stall_rd_en", filter_fifo_rd_en, 0);
         chk("stall_addr", filter_wr_addr, 10);
         chk("stall_busy", load_busy, 1);
         $display("stall cycle %0d", i);
         tick();
      end
      filter_fifo_empty   = 1'b0;
      pe_reset_ifmap_spad = 1'b0;
      #1;
      filter_writes(14, 10);
      ifmap_writes(6);
      chk("t3_await_low", pe_await, 0);
      pulse_reset_spad();
      tick();
      chk("t3_idle_busy", load_busy, 0);
      $display("txn: stalled pass complete");

      // Pass 4: asynchronous reset at k=12, then restart at address 0
      start_pass();
      filter_writes(12, 0);
      reset_n = 1'b0;
      #1;
      chk("mid_rst_busy", load_busy, 0);
      chk("mid_rst_wr_en", filter_wr_en, 0);
      chk("mid_rst_rd_en", filter_fifo_rd_en, 0);
      chk("mid_rst_addr", filter_wr_addr, 0);
      chk("mid_rst_await", pe_await, 1);
      chk("mid_rst_pe_start", pe_start, 0);
      fbase = fwr_cnt;
      tick();
      chk("mid_rst_no_write", fwr_cnt - fbase, 0);
      reset_n = 1'b1;
      start_pass();
      chk("restart_pe_start", pe_start, 1);
      filter_writes(3, 0);
      $display("txn: reset mid-load and restart");

      $display("%0d/%0d checks passed", total - fails, total);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: observed no finish expected finish");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/pe_spad_loader.md
Name: pe_spad_loader

Overview:
- Producer side of the PE compute controller. Fills the PE filter scratchpad once per pass and the ifmap scratchpad once per input channel, both from show-ahead input FIFOs.
- Holds the controller stalled through its await input until the ifmap data for the current channel is resident.
- Uses the controller's ifmap-spad-reset pulse as the "channel consumed" event to refill for the next channel.

Parameters:
- S_WIDTH, 4, filter row width field.
- q_WIDTH, 3, channels-per-PE field.
- p_WIDTH, 5, filters-per-PE field.
- n_WIDTH, 3, channel-iteration count field.
- IFMAP_ADDR_WIDTH, 4, ifmap spad address width.
- FILTER_ADDR_WIDTH, 8, filter spad address width.
- DATA_WIDTH, 16, spad word width.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- load_start  in  1  one-cycle request to begin a pass.
- load_busy  out  1  high from accepted load_start until return to IDLE.
- S, q, p, n  in  S_WIDTH/q_WIDTH/p_WIDTH/n_WIDTH  shape; sampled on load_start, held internally for the pass.
- filter_fifo_empty  in  1  filter FIFO has no word.
- filter_fifo_rd_en  out  1  pop filter FIFO.
- filter_fifo_dout  in  DATA_WIDTH  show-ahead head word.
- ifmap_fifo_empty, ifmap_fifo_rd_en, ifmap_fifo_dout  same roles for ifmap FIFO.
- filter_wr_en  out  1  filter spad write strobe.
- filter_wr_addr  out  FILTER_ADDR_WIDTH  filter spad write address.
- filter_wr_data  out  DATA_WIDTH  filter spad write data.
- ifmap_wr_en, ifmap_wr_addr (IFMAP_ADDR_WIDTH), ifmap_wr_data (DATA_WIDTH)  same roles for ifmap spad.
- pe_start  out  1  one-cycle start pulse to the PE controller.
- pe_await  out  1  stall to the PE controller; high = do not compute.
- pe_reset_ifmap_spad  in  1  PE controller pulse: current channel finished.
- pe_busy  in  1  PE controller busy.

Behaviour:
- Reset (reset_n=0, asynchronous): state=IDLE; all counters 0. Outputs: load_busy=0, pe_start=0, pe_await=1, all rd_en/wr_en=0, addresses=0. Reset mid-load aborts immediately with no further writes.
- Derived totals, computed at widths wide enough that they never truncate:
  - FT = S*q*p filter words.
  - IT = S*q ifmap words.
- Write order matches PE read order:
  - Filter: linear address k=0..FT-1 (k = i*p+j).
  - Ifmap: address m=0..IT-1.
- IDLE
  - On load_start with S, q, p and n all nonzero: latch shape, pulse pe_start for 1 cycle, go to LOAD_FILTER.
  - If any of S, q, p, n is zero: ignore load_start; load_busy stays 0.
- LOAD_FILTER
  - Per cycle: rd_en = wr_en = !filter_fifo_empty; wr_data = filter_fifo_dout (combinational, zero latency); wr_addr = k.
  - On each write, k++. On the write at k=FT-1: k=0, go to LOAD_IFMAP.
  - Empty FIFO: stall, no write, k holds.
- LOAD_IFMAP
  - Same handshake on the ifmap FIFO with counter m.
  - On the write at m=IT-1: m=0, go to RUN.
- RUN
  - pe_await=0 while in RUN only; 1 in every other state.
  - On pe_reset_ifmap_spad=1:
    - If ch < n-1: ch++, go to LOAD_IFMAP. pe_await rises on the next cycle.
    - Else: ch=0, go to DRAIN.
- DRAIN: go to IDLE on the first cycle with pe_busy=0. load_busy falls when IDLE is entered.
- Ignored events:
  - load_start while load_busy=1.
  - pe_reset_ifmap_spad outside RUN.
- Clock-phase interface: the PE controller updates on the falling edge, so its reset_ifmap_spad pulse spans exactly one rising edge. Sample it once; no edge detector is required.
- Both FIFOs are never read in the same cycle. The filter FIFO is never read outside LOAD_FILTER.

Test Plan:
- S=3,q=2,p=4,n=1, both FIFOs always non-empty, load_start:
  - pe_start pulses next cycle.
  - 24 consecutive filter writes at addr 0..23, then 6 ifmap writes at addr 0..5.
  - pe_await falls the cycle after the ifmap write at addr 5.
  - One pe_reset_ifmap_spad pulse, then pe_busy=0 → IDLE, load_busy=0.
- Same shape, n=3: three ifmap loads of 6 words each, data taken in FIFO order. pe_await is high during each reload and low in between. Exactly 24 filter writes in total.
- Filter FIFO empty for 5 cycles at k=10: no writes and no rd_en during those cycles; k resumes at 10; the written data sequence is unbroken.
- reset_n asserted at k=12: outputs at reset values immediately; a new load_start restarts writing at filter addr 0.
- Ignored events:
  - load_start with p=0: no pe_start, load_busy stays 0.
  - load_start during RUN: ignored.
  - pe_reset_ifmap_spad during LOAD_FILTER: no state change.
